// File: rtl/param_cpu_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction, decodes its fields,
// and steps through EXEC/MEM/HALT while driving register-file and memory strobes.
module param_cpu_sequencer #(
  parameter int BUS_W  = 16,
  parameter int MEM_AW = 6,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BUS_W-1:0]  IR,
  input  logic [BUS_W-1:0]  A,
  input  logic [BUS_W-1:0]  D,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              mem_req,
  output logic [MEM_AW-1:0] PC,
  output logic [REG_AW-1:0] DA,
  output logic [REG_AW-1:0] AA,
  output logic [REG_AW-1:0] BA,
  output logic [2:0]        FS,
  output logic              MB,
  output logic [1:0]        resultSource,
  output logic              RW,
  output logic              MW,
  output logic              IL,
  output logic              EOE,
  output logic [2:0]        state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_BZ   = 4'd11;
  localparam logic [3:0] OP_BNZ  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_HLT  = 4'd15;

  logic [2:0]               state_q, state_d;
  logic [MEM_AW-1:0]        pc_q, pc_d;
  logic [3:0]               opcode_q;
  logic [REG_AW-1:0]        da_q, aa_q, ba_q;
  logic signed [MEM_AW-1:0] ba_ext;
  logic                     a_zero;
  logic                     unused_data;

  // D is a reserved bus; it must never influence control.
  assign unused_data = ^D;

  assign ba_ext = $signed(ba_q);
  assign a_zero = (A == '0);

  // Memory handshake: mem_req is held high in FETCH/MEM and the transfer
  // completes in the cycle mem_ack is sampled high on the rising edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
          pc_d    = pc_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode_q)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_HLT:       state_d = S_HALT;
          OP_BZ:        if (a_zero)  pc_d = pc_q + ba_ext;
          OP_BNZ:       if (!a_zero) pc_d = pc_q + ba_ext;
          OP_JMP:       pc_d = A[MEM_AW-1:0];
          default:      ;
        endcase
      end
      S_MEM:  if (mem_ack) state_d = S_FETCH;
      S_HALT: if (resume)  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      opcode_q <= '0;
      da_q     <= '0;
      aa_q     <= '0;
      ba_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_FETCH && mem_ack) begin
        opcode_q <= IR[BUS_W-1 -: 4];
        da_q     <= IR[BUS_W-5 -: REG_AW];
        aa_q     <= IR[BUS_W-5-REG_AW -: REG_AW];
        ba_q     <= IR[BUS_W-5-2*REG_AW -: REG_AW];
      end
    end
  end

  // Strobes are gated by reset so they drop immediately when reset asserts.
  always_comb begin
    mem_req      = 1'b0;
    IL           = 1'b0;
    FS           = 3'd0;
    MB           = 1'b0;
    resultSource = 2'd0;
    RW           = 1'b0;
    MW           = 1'b0;
    EOE          = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          IL      = mem_ack;
        end
        S_EXEC: begin
          if (!opcode_q[3]) begin
            FS = opcode_q[2:0];
            RW = 1'b1;
          end else if (opcode_q == OP_ADDI) begin
            MB = 1'b1;
            RW = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            if (opcode_q == OP_LD) begin
              RW           = 1'b1;
              resultSource = 2'd1;
            end else begin
              MW = 1'b1;
            end
          end
        end
        S_HALT:  EOE = 1'b1;
        default: ;
      endcase
    end
  end

  assign PC    = pc_q;
  assign DA    = da_q;
  assign AA    = aa_q;
  assign BA    = ba_q;
  assign state = state_q;

endmodule

// File: doc/param_cpu_sequencer.md
PARAM_CPU_SEQUENCER -- requirements
Module: param_cpu_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BUS_W, 16, data/instruction width; BUS_W >= 4+3*REG_AW.
- MEM_AW, 6, program-counter width; MEM_AW >= REG_AW.
- REG_AW, 4, register-address field width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- IR, in, BUS_W, instruction word from program memory.
- A, in, BUS_W, register-file port A value (jump target, branch test).
- D, in, BUS_W, reserved data bus; unused by control logic in this version.
- mem_ack, in, 1, memory completion strobe.
- resume, in, 1, leaves HALT.
- mem_req, out, 1, memory request (fetch or data).
- PC, out, MEM_AW, fetch address.
- DA / AA / BA, out, REG_AW each, latched register fields.
- FS, out, 3, ALU function select.
- MB, out, 1, immediate select for the B operand.
- resultSource, out, 2: 0 = ALU, 1 = memory.
- RW, out, 1, register write.
- MW, out, 1, memory write.
- IL, out, 1, instruction load.
- EOE, out, 1, end of execution.
- state, out, 3, current FSM state.

Function
REQ-003 Instruction fields SHALL be: opcode = IR[BUS_W-1 -: 4], DA = next REG_AW bits, AA = next REG_AW bits, BA = next REG_AW bits.
REQ-004 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4. Codes 5-7 are unreachable; if entered, the FSM SHALL go to FETCH.
REQ-005 FETCH SHALL assert mem_req=1 and IL=mem_ack.
REQ-006 On a FETCH edge with mem_ack=1, the block SHALL latch the opcode and DA/AA/BA, set PC<=PC+1 (mod 2^MEM_AW), and go to DECODE. Without mem_ack it SHALL stay in FETCH.
REQ-007 DECODE SHALL last one cycle, then go to EXEC.
REQ-008 For opcodes 0-7 (ALU ops), EXEC SHALL drive FS=opcode[2:0], MB=0, resultSource=0, RW=1 for one cycle, then go to FETCH.
REQ-009 For opcode 8 (ADDI), EXEC SHALL drive FS=0, MB=1, resultSource=0, RW=1 for one cycle, then go to FETCH.
REQ-010 For opcodes 9 (LD) and 10 (ST), EXEC SHALL go to MEM.
REQ-011 MEM SHALL assert mem_req=1 and stay in MEM until mem_ack=1.
- In the ack cycle: LD drives RW=1 with resultSource=1; ST drives MW=1.
- The next state is FETCH.
REQ-012 Opcode 11 (BZ) SHALL set PC<=PC+sext(BA) if A==0. Opcode 12 (BNZ) SHALL do the same if A!=0. Both update on the EXEC edge.
- PC here already holds instruction address+1.
- BA is sign-extended from REG_AW to MEM_AW; arithmetic is mod 2^MEM_AW.
REQ-013 Opcode 13 (JMP) SHALL set PC<=A[MEM_AW-1:0] on the EXEC edge.
REQ-014 Opcode 14 (NOP) SHALL return to FETCH with no strobes asserted.
REQ-015 Opcode 15 (HLT) SHALL go to HALT.
- EOE=1 for every cycle in HALT.
- The FSM stays in HALT until resume=1, then goes to FETCH with PC unchanged.
REQ-016 Strobe defaults outside their stated cycles: RW=MW=IL=mem_req=MB=0, FS=0, resultSource=0. All strobes SHALL be decoded from registered state and opcode only, with no dependency on D.
REQ-017 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-018 resume SHALL be ignored outside HALT.
REQ-019 Minimum latency SHALL be: ALU/ADDI/branch/JMP/NOP, 3 cycles; LD/ST, 4 cycles.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force:
- state=FETCH, PC=0;
- opcode/DA/AA/BA=0;
- RW=MW=IL=EOE=mem_req=0.
REQ-021 Reset asserted mid-instruction (including in MEM or HALT) SHALL abandon the instruction with no further RW/MW. Fetch SHALL restart from PC=0 on the first clock edge after release.

Verification
REQ-022 Reset, then IR=0x1234 (SUB, DA=2, AA=3, BA=4) with mem_ack held 1 -> cycle 1 IL=1; cycle 3 RW=1, FS=1, DA=2; PC=1.
REQ-023 LD with mem_ack low for 3 MEM cycles -> RW=0 while waiting; RW=1 with resultSource=1 only in the ack cycle; total 7 cycles.
REQ-024 Instruction at PC=5 is BZ with BA=0xE, A=0 -> PC=4. Same instruction with A=1 -> PC=6.
REQ-025 PC=63, any fetch -> PC wraps to 0. JMP with A=0xFFC5 -> PC=0x05.
REQ-026 HLT -> EOE=1 and state=4, held 10 cycles with mem_ack toggling. Then resume=1 -> FETCH at the unchanged PC, EOE=0.
REQ-027 reset=0 asserted during the ST MEM wait -> MW never asserted, and the outputs match REQ-020 immediately, before the next clock edge.
